// File: rtl/workout_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : workout_sequencer_if
//  Description : Control/timer/status bundle of the interval-workout sequencer.
//                master = user-control, timer and display side
//                slave  = the sequencer itself
//  Revision    : 1.0  initial release
// ============================================================================
interface workout_sequencer_if #(
    parameter int DUR_W   = 32,
    parameter int ROUND_W = 8
) ();
    // user control
    logic               start;
    logic               pause;
    logic               resume;
    logic               abort;
    logic [DUR_W-1:0]   cfg_warmup;
    logic [DUR_W-1:0]   cfg_work;
    logic [DUR_W-1:0]   cfg_rest;
    logic [DUR_W-1:0]   cfg_cool;
    logic [ROUND_W-1:0] cfg_rounds;
    // phase timer
    logic               tmr_timeout;
    logic               tmr_rst;
    logic               tmr_enable;
    logic [DUR_W-1:0]   tmr_duration;
    // status
    logic [2:0]         phase;
    logic [ROUND_W-1:0] round;
    logic               paused;
    logic               busy;
    logic               phase_start;
    logic               done;

    modport master (
        output start, pause, resume, abort,
        output cfg_warmup, cfg_work, cfg_rest, cfg_cool, cfg_rounds,
        output tmr_timeout,
        input  tmr_rst, tmr_enable, tmr_duration,
        input  phase, round, paused, busy, phase_start, done
    );

    modport slave (
        input  start, pause, resume, abort,
        input  cfg_warmup, cfg_work, cfg_rest, cfg_cool, cfg_rounds,
        input  tmr_timeout,
        output tmr_rst, tmr_enable, tmr_duration,
        output phase, round, paused, busy, phase_start, done
    );
endinterface
`default_nettype wire

// File: rtl/workout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : workout_sequencer
//  Description : Sequences one shared phase timer through warm-up, N work/rest
//                rounds and cool-down; reports phase, round and pause state.
//  Revision    : 1.0  initial release
// ============================================================================
module workout_sequencer #(
    parameter int DUR_W   = 32,
    parameter int ROUND_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    workout_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WARMUP = 3'd2,
        S_WORK   = 3'd3,
        S_REST   = 3'd4,
        S_COOL   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_next;
    logic [ROUND_W-1:0] round_q;
    logic [ROUND_W-1:0] round_next;
    logic               paused_q;
    logic               paused_next;
    logic               abort_take;
    logic [DUR_W-1:0]   duration_next;
    logic               phase_start_next;
    logic               in_phase;

    // configuration captured at start; later cfg_* changes are invisible
    logic [DUR_W-1:0]   lat_warmup;
    logic [DUR_W-1:0]   lat_work;
    logic [DUR_W-1:0]   lat_rest;
    logic [DUR_W-1:0]   lat_cool;
    logic [ROUND_W-1:0] lat_rounds;

    // registered status outputs
    logic               tmr_rst_q;
    logic [DUR_W-1:0]   duration_q;
    logic               busy_q;
    logic               phase_start_q;
    logic               done_q;

    assign in_phase = (state_q inside {S_WARMUP, S_WORK, S_REST, S_COOL});

    // Next-state, round and pause decisions; abort overrides timeout, which overrides pause/resume
    always_comb begin
        state_next       = state_q;
        round_next       = round_q;
        paused_next      = paused_q;
        abort_take       = 1'b0;
        duration_next    = '0;
        phase_start_next = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_START;
                    round_next = '0;
                end
            end
            S_START:  state_next = S_WARMUP;
            S_WARMUP: begin
                if (bus.tmr_timeout) begin
                    state_next = S_WORK;
                    round_next = round_q + ROUND_W'(1);
                end
            end
            S_WORK: begin
                if (bus.tmr_timeout) begin
                    // the last work round goes straight to cool-down, no rest
                    state_next = (round_q >= lat_rounds) ? S_COOL : S_REST;
                end
            end
            S_REST: begin
                if (bus.tmr_timeout) begin
                    state_next = S_WORK;
                    round_next = round_q + ROUND_W'(1);
                end
            end
            S_COOL: begin
                if (bus.tmr_timeout) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                round_next = '0;
            end
            default: begin
                state_next = S_IDLE;
                round_next = '0;
            end
        endcase

        // a simultaneous pause and resume cancel each other out
        if (in_phase && (bus.pause != bus.resume)) begin
            paused_next = bus.pause;
        end

        // pause only has meaning inside a timed phase
        if (!(state_next inside {S_WARMUP, S_WORK, S_REST, S_COOL})) begin
            paused_next = 1'b0;
        end

        if (bus.abort && (state_q != S_IDLE)) begin
            state_next  = S_IDLE;
            round_next  = '0;
            paused_next = 1'b0;
            abort_take  = 1'b1;
        end

        case (state_next)
            S_WARMUP: duration_next = lat_warmup;
            S_WORK:   duration_next = lat_work;
            S_REST:   duration_next = lat_rest;
            S_COOL:   duration_next = lat_cool;
            default:  duration_next = '0;
        endcase

        phase_start_next = (state_next inside {S_WARMUP, S_WORK, S_REST, S_COOL}) &&
                           (state_next != state_q);
    end

    // State register plus registered copies of every status output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            round_q       <= '0;
            paused_q      <= 1'b0;
            tmr_rst_q     <= 1'b0;
            duration_q    <= '0;
            busy_q        <= 1'b0;
            phase_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_next;
            round_q       <= round_next;
            paused_q      <= paused_next;
            tmr_rst_q     <= abort_take || (state_next == S_START);
            duration_q    <= duration_next;
            busy_q        <= (state_next != S_IDLE);
            phase_start_q <= phase_start_next;
            done_q        <= (state_next == S_DONE);
        end
    end

    // Capture the workout configuration when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_warmup <= '0;
            lat_work   <= '0;
            lat_rest   <= '0;
            lat_cool   <= '0;
            lat_rounds <= ROUND_W'(1);
        end else if ((state_q == S_IDLE) && bus.start) begin
            lat_warmup <= bus.cfg_warmup;
            lat_work   <= bus.cfg_work;
            lat_rest   <= bus.cfg_rest;
            lat_cool   <= bus.cfg_cool;
            lat_rounds <= (bus.cfg_rounds == '0) ? ROUND_W'(1) : bus.cfg_rounds;
        end
    end

    // tmr_enable stays combinational so the timer never counts in its timeout cycle
    assign bus.tmr_enable   = in_phase & ~paused_q & ~bus.tmr_timeout;
    assign bus.tmr_rst      = tmr_rst_q;
    assign bus.tmr_duration = duration_q;
    assign bus.phase        = state_q;
    assign bus.round        = round_q;
    assign bus.paused       = paused_q;
    assign bus.busy         = busy_q;
    assign bus.phase_start  = phase_start_q;
    assign bus.done         = done_q;

endmodule
`default_nettype wire

// File: doc/workout_sequencer.md
# workout_sequencer

Interval-workout controller that sequences the single shared phase timer through warm-up, N work/rest rounds and cool-down. It sits between the user-control logic (buttons and configuration registers) and the timer. It drives the timer's clear, enable and duration inputs and consumes its one-cycle timeout pulse. It exposes the current phase and round to the display and buzzer logic.

## Interface
Parameters:
- DUR_W, 32, width of all duration values in clock cycles.
- ROUND_W, 8, width of round count and round index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins a workout when IDLE.
- pause  in  1  pulse; freezes the active phase.
- resume  in  1  pulse; continues a paused phase.
- abort  in  1  pulse; cancels the workout from any state.
- cfg_warmup, cfg_work, cfg_rest, cfg_cool  in  DUR_W each  phase durations D, latched on start.
- cfg_rounds  in  ROUND_W  number of work rounds, latched on start; 0 is treated as 1.
- tmr_timeout  in  1  timer expiry pulse.
- tmr_rst  out  1  synchronous clear to the timer.
- tmr_enable  out  1  timer count enable.
- tmr_duration  out  DUR_W  timer compare value.
- phase  out  3  0 IDLE, 1 START, 2 WARMUP, 3 WORK, 4 REST, 5 COOL, 6 DONE.
- round  out  ROUND_W  current round (1..N); 0 in IDLE/START/WARMUP.
- paused  out  1  pause flag.
- busy  out  1  high whenever phase is not IDLE.
- phase_start  out  1  one-cycle pulse on entry to WARMUP, WORK, REST or COOL.
- done  out  1  one-cycle pulse in the DONE state.

## Operation
- State sequence: IDLE -> START -> WARMUP -> WORK(1) -> REST -> WORK(2) -> … -> WORK(N) -> COOL -> DONE -> IDLE.
- REST follows every WORK except the last.
- IDLE:
  - A start pulse latches all cfg_* inputs and sets round=0.
  - The next state is START.
  - start is ignored in any other state.
- START lasts one cycle.
  - tmr_rst=1 and tmr_enable=0.
  - The next state is WARMUP.
- Phase states (WARMUP, WORK, REST, COOL):
  - tmr_duration holds the latched D of the phase.
  - tmr_enable = active & ~paused & ~tmr_timeout. This is combinational on tmr_timeout, so the timer never counts in its timeout cycle.
  - tmr_timeout=1 advances the state on the next edge. tmr_duration and round update on that same edge.
- round increments on every entry to WORK.
- DONE lasts one cycle with done=1, then the state returns to IDLE.
- Zero durations are not skipped. D=0 yields the minimum phase length.
- Pause and resume:
  - pause is honoured only in phase states while not paused. It sets paused=1, so tmr_enable=0 and the timer holds its count.
  - resume clears paused.
  - pause and resume asserted in the same cycle are both ignored.
  - pause or resume in any other state is ignored.
- abort, from any non-IDLE state:
  - Next state is IDLE, paused=0 and round=0.
  - tmr_rst=1 for one cycle.
  - No done pulse.
- Priority: rst > abort > tmr_timeout > pause/resume.
- Timeout and pause in the same cycle: the state advances and paused is also set, so the new phase begins paused. Its phase_start still pulses.

## Timing
- Reset values: phase=IDLE, round=0, paused=0, busy=0, tmr_rst=0, tmr_enable=0, tmr_duration=0, phase_start=0, done=0.
- All outputs are registered except tmr_enable.
- Timer contract: the timer counts one per enabled cycle from 0. It pulses tmr_timeout on the edge after its count reaches D, and its count self-clears to 0 on timeout.
- A phase with duration D therefore needs D+1 enabled cycles plus one timeout cycle. Unpaused residence is D+2 cycles.
- Paused cycles add 1:1 to residence.
- Total unpaused workout length, from the edge sampling start to the edge setting DONE: 1 + (Dw+2) + N(Dk+2) + (N-1)(Dr+2) + (Dc+2).
- phase_start is high in the first cycle of each phase state.
- The timer is cleared only via tmr_rst, on start and on abort.
- Changing cfg_* mid-workout has no effect.

## Test plan
- Nominal run (warmup=2, work=3, rest=1, cool=2, rounds=2; start at edge 0):
  - START is entered at edge 0, WARMUP at 1, WORK(1) at 5, REST at 10, WORK(2) at 13, COOL at 18 and DONE at 22.
  - done is high for one cycle. round reads 1 then 2.
  - tmr_duration reads 2, 3, 1, 3, 2.
- Pause: same config, pause at edge 7 and resume at edge 17.
  - tmr_enable is 0 for those 10 cycles and the timer count is held.
  - DONE is reached at edge 32.
- Abort mid-REST: at edge 11 abort=1.
  - Next cycle: phase=IDLE, tmr_rst=1, round=0, no done.
  - A subsequent start completes normally from a cleared timer.
- Edge configuration: cfg_rounds=0 with all durations 0.
  - Runs as 1 round: WARMUP, WORK, COOL, 2 cycles each.
  - DONE at edge 7, with no REST state.
- Simultaneous events:
  - tmr_timeout and pause in the same cycle: the new phase is entered paused with phase_start=1.
  - abort and tmr_timeout in the same cycle: IDLE.
  - start while busy: ignored.
  - pause and resume together: no change.
- Reset mid-WORK: rst=1 for one cycle forces every output to its reset value the next cycle.
